counter_sweep_ctrl: RTL and testbench

//   Sequencer for the 8-bit loadable up/down counter (counter_298A). Drives the counter's
//   en/load/up/oe/d pins to produce programmed sweeps between LO and HI: sawtooth
//   (count up, reload) or triangle (up/down bounce), with a prescaled step rate.

---
 rtl/counter_ctrl_pkg.sv | 18 +
 rtl/tick_divider.sv | 38 +++
 rtl/counter_sweep_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_ctrl_pkg
//   Shared definitions for the counter sweep sequencer: FSM state encoding
//   and sweep-mode codes.
// -----------------------------------------------------------------------------
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic MODE_SAW = 1'b0;  // count up to hi, reload lo
    localparam logic MODE_TRI = 1'b1;  // bounce lo -> hi -> lo

endpackage

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
//   Prescaler for the sweep step rate. While enabled, counts 0..i_div and
//   raises o_tick (combinationally) in the cycle the count equals i_div, then
//   wraps to 0. Step period is therefore i_div+1 cycles; i_div=0 ticks every
//   enabled cycle.
// Ports
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   i_clear   in   force count to 0 (takes precedence over i_enable)
//   i_enable  in   advance the prescaler this cycle
//   i_div     in   divisor (terminal count)
//   o_tick    out  one-cycle step strobe
// -----------------------------------------------------------------------------
module tick_divider #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    assign o_tick = i_enable && (r_cnt == i_div);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/counter_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// counter_sweep_ctrl
//   Sequencer that drives an 8-bit loadable up/down counter through
//   programmed sweeps between lo and hi: sawtooth (up, reload) or triangle
//   (up/down bounce), at a prescaled step rate, for reps sweeps (0 = forever).
// Ports
//   clk, reset     clock, synchronous active-high reset
//   start          launch a run; config sampled this cycle (ignored while busy)
//   stop           abort run, IDLE next cycle (beats start and internal events)
//   mode           0 sawtooth, 1 triangle
//   lo, hi         sweep bounds (start with lo > hi pulses cfg_err)
//   div            prescaler divisor, step period div+1
//   reps           sweeps to run, 0 = until stop
//   cnt_q          counter output fed back
//   cnt_en/load    counter controls, combinational (never both high)
//   cnt_up         counter direction, combinational
//   cnt_oe, busy   registered, high in LOAD/RUN
//   cnt_d          latched lo
//   done           one-cycle pulse while in DONE
//   cfg_err        one-cycle pulse after a rejected start
//   dbg_state      current FSM state for observation
// Handshake: start is a single-cycle request accepted only in IDLE; there is
//   no back-pressure, busy tells the requester whether a run is in progress.
// -----------------------------------------------------------------------------
module counter_sweep_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8,
    parameter int REP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [DIV_W-1:0] div,
    input  logic [REP_W-1:0] reps,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic             cnt_up,
    output logic             cnt_oe,
    output logic [WIDTH-1:0] cnt_d,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [1:0]       dbg_state
);

    state_t           r_state;
    logic             r_dir;      // 1 = counting up
    logic [REP_W-1:0] r_sweeps;
    logic             r_mode;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic [DIV_W-1:0] r_div;
    logic [REP_W-1:0] r_reps;
    logic             r_busy;
    logic             r_oe;
    logic             r_done;
    logic             r_cfg_err;

    state_t           w_next;
    logic             w_en;
    logic             w_load;
    logic             w_up;
    logic             w_dir_next;
    logic [REP_W-1:0] w_sweeps_next;
    logic [REP_W-1:0] w_sweeps_inc;
    logic             w_latch;
    logic             w_cfg_err;
    logic             w_div_clear;
    logic             w_div_en;
    logic             w_tick;
    logic             w_complete;
    logic             w_last;

    tick_divider #(.DIV_W(DIV_W)) u_div (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_div_clear),
        .i_enable (w_div_en),
        .i_div    (r_div),
        .o_tick   (w_tick)
    );

    assign w_sweeps_inc = r_sweeps + 1'b1;
    assign w_last       = (r_reps != '0) && (w_sweeps_inc == r_reps);

    always_comb begin
        w_next        = r_state;
        w_en          = 1'b0;
        w_load        = 1'b0;
        w_up          = 1'b1;
        w_dir_next    = r_dir;
        w_sweeps_next = r_sweeps;
        w_latch       = 1'b0;
        w_cfg_err     = 1'b0;
        w_div_clear   = 1'b0;
        w_div_en      = 1'b0;
        w_complete    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (lo <= hi) begin
                        w_latch = 1'b1;
                        w_next  = ST_LOAD;
                    end else begin
                        w_cfg_err = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                w_load        = 1'b1;
                w_dir_next    = 1'b1;
                w_sweeps_next = '0;
                w_div_clear   = 1'b1;
                w_next        = ST_RUN;
            end
            ST_RUN: begin
                w_div_en = 1'b1;
                if (w_tick) begin
                    // Decision uses the live counter value so a step can be
                    // issued every cycle when div is 0.
                    if (r_lo == r_hi) begin
                        w_complete = 1'b1;
                    end else if (r_dir) begin
                        if (cnt_q < r_hi) begin
                            w_en = 1'b1;
                        end else if (r_mode == MODE_SAW) begin
                            w_complete = 1'b1;
                            w_load     = 1'b1;
                        end else begin
                            w_dir_next = 1'b0;
                            w_en       = 1'b1;
                            w_up       = 1'b0;
                        end
                    end else begin
                        if (cnt_q > r_lo) begin
                            w_en = 1'b1;
                            w_up = 1'b0;
                        end else begin
                            w_complete = 1'b1;
                            w_dir_next = 1'b1;
                            w_en       = 1'b1;
                        end
                    end

                    if (w_complete) begin
                        if (w_last) begin
                            // Final sweep: leave the counter where it ended.
                            w_en   = 1'b0;
                            w_load = 1'b0;
                            w_up   = 1'b1;
                            w_next = ST_DONE;
                        end else if (r_sweeps != '1) begin
                            w_sweeps_next = w_sweeps_inc;
                        end
                    end
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase

        if (stop) begin
            w_next    = ST_IDLE;
            w_en      = 1'b0;
            w_load    = 1'b0;
            w_latch   = 1'b0;
            w_cfg_err = 1'b0;
        end

        // Counter controls are combinational, so reset must mask them too.
        if (reset) begin
            w_en   = 1'b0;
            w_load = 1'b0;
            w_up   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_dir     <= 1'b1;
            r_sweeps  <= '0;
            r_mode    <= 1'b0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_div     <= '0;
            r_reps    <= '0;
            r_busy    <= 1'b0;
            r_oe      <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_dir     <= w_dir_next;
            r_sweeps  <= w_sweeps_next;
            if (w_latch) begin
                r_mode <= mode;
                r_lo   <= lo;
                r_hi   <= hi;
                r_div  <= div;
                r_reps <= reps;
            end
            r_busy    <= (w_next == ST_LOAD) || (w_next == ST_RUN);
            r_oe      <= (w_next == ST_LOAD) || (w_next == ST_RUN);
            r_done    <= (w_next == ST_DONE);
            r_cfg_err <= w_cfg_err;
        end
    end

    assign cnt_en    = w_en;
    assign cnt_load  = w_load;
    assign cnt_up    = w_up;
    assign cnt_oe    = r_oe;
    assign cnt_d     = r_lo;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cfg_err   = r_cfg_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       mode;
  logic [7:0] lo, hi, div, reps;
  logic [7:0] cnt_q = 8'd0;
  logic       cnt_en, cnt_load, cnt_up, cnt_oe;
  logic [7:0] cnt_d;
  logic       busy, done, cfg_err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;
  bit pend     = 0;
  logic [7:0] exp_q[$];

  counter_sweep_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .lo(lo), .hi(hi), .div(div), .reps(reps), .cnt_q(cnt_q),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_up(cnt_up), .cnt_oe(cnt_oe),
    .cnt_d(cnt_d), .busy(busy), .done(done), .cfg_err(cfg_err),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // behavioural model of the loadable up/down counter
  always @(posedge clk) begin
    if (cnt_load) cnt_q <= cnt_d;
    else if (cnt_en) cnt_q <= cnt_up ? cnt_q + 8'd1 : cnt_q - 8'd1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // scoreboard: every en/load issued must produce the next queued counter value
  always @(negedge clk) begin
    if (pend) begin
      pend = 0;
      if (exp_q.size() == 0) check_eq("q_unexpected_step", exp_q.size(), 1);
      else check_eq("q_step", cnt_q, exp_q.pop_front());
    end
    if (cnt_en || cnt_load) pend = 1;
    if (cnt_en && cnt_load) viol++;
    if ((cnt_en || cnt_load) && !busy) viol++;
  end

  // driver tasks
  task automatic do_start(input logic m, input logic [7:0] l, input logic [7:0] h,
                          input logic [7:0] d, input logic [7:0] r);
    @(posedge clk); #1;
    mode = m; lo = l; hi = h; div = d; reps = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // config changes during the run must be ignored
    lo   = 8'($urandom_range(0, 255));
    hi   = 8'($urandom_range(0, 255));
    div  = 8'($urandom_range(0, 255));
    reps = 8'($urandom_range(0, 255));
    mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string tag, input int exp_cycles, input logic [7:0] exp_lo);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check_eq({tag, "_load"}, cnt_load, 1);
        check_eq({tag, "_busy"}, busy, 1);
        check_eq({tag, "_oe"}, cnt_oe, 1);
        check_eq({tag, "_d"}, cnt_d, exp_lo);
      end
      if (done) seen = 1;
    end
    check_eq({tag, "_done_cycle"}, n, exp_cycles);
    check_eq({tag, "_busy_at_done"}, busy, 0);
    check_eq({tag, "_oe_at_done"}, cnt_oe, 0);
    @(negedge clk);
    check_eq({tag, "_done_pulse"}, done, 0);
    check_eq({tag, "_state_idle"}, dbg_state, 0);
    check_eq({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_oe"}, cnt_oe, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_cfg_err"}, cfg_err, 0);
    check_eq({tag, "_en"}, cnt_en, 0);
    check_eq({tag, "_load"}, cnt_load, 0);
    check_eq({tag, "_up"}, cnt_up, 1);
    check_eq({tag, "_d"}, cnt_d, 0);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    lo = 8'd0; hi = 8'd0; div = 8'd0; reps = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // rejected configuration
    do_start(1'b0, 8'd9, 8'd4, 8'd0, 8'd1);
    @(negedge clk);
    check_eq("cfgerr_pulse", cfg_err, 1);
    check_eq("cfgerr_busy", busy, 0);
    @(negedge clk);
    check_eq("cfgerr_clear", cfg_err, 0);
    check_eq("cfgerr_busy2", busy, 0);
    check_eq("cfgerr_state", dbg_state, 0);

    // sawtooth 3..6, two sweeps, step every cycle
    exp_q = {8'd3, 8'd4, 8'd5, 8'd6, 8'd3, 8'd4, 8'd5, 8'd6};
    do_start(1'b0, 8'd3, 8'd6, 8'd0, 8'd2);
    wait_done("saw", 10, 8'd3);
    check_eq("saw_q_hold", cnt_q, 6);

    // triangle 10..12, one sweep, step every 2 cycles
    exp_q = {8'd10, 8'd11, 8'd12, 8'd11, 8'd10};
    do_start(1'b1, 8'd10, 8'd12, 8'd1, 8'd1);
    wait_done("tri", 12, 8'd10);
    check_eq("tri_q_hold", cnt_q, 10);

    // degenerate lo == hi: a load and no steps
    exp_q = {8'd7};
    do_start(1'b0, 8'd7, 8'd7, 8'd0, 8'd3);
    wait_done("flat", 5, 8'd7);

    // endless triangle aborted by stop
    exp_q = {8'd20, 8'd21, 8'd22, 8'd23, 8'd22};
    do_start(1'b1, 8'd20, 8'd23, 8'd2, 8'd0);
    repeat (13) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_oe", cnt_oe, 0);
    check_eq("stop_state", dbg_state, 0);
    check_eq("stop_done", done, 0);
    repeat (4) @(negedge clk);
    check_eq("stop_q_frozen", cnt_q, 22);
    check_eq("stop_queue_empty", exp_q.size(), 0);

    // reset in the middle of a run, then a fresh run
    exp_q = {8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    do_start(1'b0, 8'd0, 8'd200, 8'd0, 8'd0);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    check_eq("midrst_q", cnt_q, 4);
    check_eq("midrst_queue_empty", exp_q.size(), 0);

    exp_q = {8'd1, 8'd2};
    do_start(1'b0, 8'd1, 8'd2, 8'd0, 8'd1);
    wait_done("post_rst", 4, 8'd1);

    check_eq("protocol_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
